// File: rtl/seq_store.sv
// Colour sequence store for the Genius game: appends one colour per round and plays the sequence on four LEDs.
// Optional replay input is enabled by defining SEQ_STORE_REPLAY_EN.
module seq_store #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_LEN    = 32,
  parameter int ON_CYCLES  = 50000000,
  parameter int OFF_CYCLES = 25000000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DATA_WIDTH-1:0]        rnd_in,
  input  logic                         start_round,
  input  logic                         clear,
`ifdef SEQ_STORE_REPLAY_EN
  input  logic                         replay,
`endif
  input  logic [$clog2(MAX_LEN)-1:0]   rd_idx,
  output logic [1:0]                   rd_color,
  output logic [$clog2(MAX_LEN+1)-1:0] seq_len,
  output logic [3:0]                   led_onehot,
  output logic                         busy,
  output logic                         done,
  output logic                         full
);

  localparam int IW   = $clog2(MAX_LEN);
  localparam int LW   = $clog2(MAX_LEN + 1);
  localparam int TMAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] ON_LAST  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(OFF_CYCLES - 1);
  localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_LEN);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    APPEND   = 2'd1,
    SHOW_ON  = 2'd2,
    SHOW_OFF = 2'd3
  } state_t;

  state_t          state_r;
  state_t          next_s;
  logic [TW-1:0]   timer_r;
  logic [IW-1:0]   idx_r;
  logic [LW-1:0]   seq_len_r;
  logic            done_r;
  logic [1:0]      mem_r [MAX_LEN];

  logic            full_s;
  logic            last_s;
  logic            wr_en_s;
  logic            replay_ok_s;
  logic [3:0]      led_s;
  logic            busy_s;
  logic            unused_s;

  function automatic logic [3:0] color_onehot(input logic [1:0] c);
    case (c)
      2'd0:    color_onehot = 4'b0001;
      2'd1:    color_onehot = 4'b0010;
      2'd2:    color_onehot = 4'b0100;
      2'd3:    color_onehot = 4'b1000;
      default: color_onehot = 4'b0000;
    endcase
  endfunction

  assign full_s   = (seq_len_r == LEN_MAX);
  assign last_s   = (LW'(idx_r) == (seq_len_r - LW'(1)));
  assign wr_en_s  = (state_r == APPEND) && !full_s && !clear;
  assign unused_s = ^rnd_in[DATA_WIDTH-1:2];

`ifdef SEQ_STORE_REPLAY_EN
  assign replay_ok_s = replay && (seq_len_r != {LW{1'b0}});
`else
  assign replay_ok_s = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state logic; clear overrides every transition
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_round) begin
          next_s = APPEND;
        end else if (replay_ok_s) begin
          next_s = SHOW_ON;
        end else begin
          next_s = IDLE;
        end
      end
      APPEND: begin
        next_s = SHOW_ON;
      end
      SHOW_ON: begin
        if (timer_r == ON_LAST) begin
          next_s = SHOW_OFF;
        end else begin
          next_s = SHOW_ON;
        end
      end
      SHOW_OFF: begin
        if (timer_r != OFF_LAST) begin
          next_s = SHOW_OFF;
        end else if (last_s) begin
          next_s = IDLE;
        end else begin
          next_s = SHOW_ON;
        end
      end
      default: begin
        next_s = IDLE;
      end
    endcase
    if (clear) begin
      next_s = IDLE;
    end else begin
      next_s = next_s;
    end
  end

  // Phase timer restarts on every state change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_r <= {TW{1'b0}};
    end else if (clear || (next_s != state_r)) begin
      timer_r <= {TW{1'b0}};
    end else if ((state_r == SHOW_ON) || (state_r == SHOW_OFF)) begin
      timer_r <= timer_r + TW'(1);
    end else begin
      timer_r <= {TW{1'b0}};
    end
  end

  // Playback index: held at zero outside playback, advances after each dark gap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r <= {IW{1'b0}};
    end else if (clear || (state_r == IDLE) || (state_r == APPEND)) begin
      idx_r <= {IW{1'b0}};
    end else if ((state_r == SHOW_OFF) && (timer_r == OFF_LAST) && !last_s) begin
      idx_r <= idx_r + IW'(1);
    end else begin
      idx_r <= idx_r;
    end
  end

  // Sequence length and end-of-playback pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_len_r <= {LW{1'b0}};
      done_r    <= 1'b0;
    end else begin
      if (clear) begin
        seq_len_r <= {LW{1'b0}};
      end else if (wr_en_s) begin
        seq_len_r <= seq_len_r + LW'(1);
      end else begin
        seq_len_r <= seq_len_r;
      end
      done_r <= !clear && (state_r == SHOW_OFF) && (next_s == IDLE);
    end
  end

  // Colour buffer; contents survive reset by design
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[seq_len_r[IW-1:0]] <= rnd_in[1:0];
    end
  end

  // LED drive and busy decode from registered state
  always_comb begin
    led_s  = 4'b0000;
    busy_s = 1'b0;
    if (state_r == SHOW_ON) begin
      led_s = color_onehot(mem_r[idx_r]);
    end else begin
      led_s = 4'b0000;
    end
    if (state_r != IDLE) begin
      busy_s = 1'b1;
    end else begin
      busy_s = 1'b0;
    end
  end

  assign rd_color   = mem_r[rd_idx];
  assign seq_len    = seq_len_r;
  assign led_onehot = led_s;
  assign busy       = busy_s;
  assign done       = done_r;
  assign full       = full_s;

endmodule

// File: tb/tb_seq_store.sv
// Directed self-checking bench for seq_store with ON=4, OFF=2, MAX_LEN=4.
module tb_seq_store;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rnd_in;
  logic       start_round;
  logic       clear;
  logic [1:0] rd_idx;
  logic [1:0] rd_color;
  logic [2:0] seq_len;
  logic [3:0] led_onehot;
  logic       busy;
  logic       done;
  logic       full;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_store #(
    .DATA_WIDTH(8),
    .MAX_LEN(4),
    .ON_CYCLES(4),
    .OFF_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rnd_in(rnd_in),
    .start_round(start_round),
    .clear(clear),
    .rd_idx(rd_idx),
    .rd_color(rd_color),
    .seq_len(seq_len),
    .led_onehot(led_onehot),
    .busy(busy),
    .done(done),
    .full(full)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; start_round is sampled at the next posedge, rnd_in held through APPEND.
  task automatic start_rnd(input logic [7:0] r);
    rnd_in      = r;
    start_round = 1'b1;
    @(negedge clk);
    start_round = 1'b0;
    chk("append_busy", 32'(busy), 32'd1);
    chk("append_led", 32'(led_onehot), 32'd0);
  endtask

  // Expects n colours (2 bits each, first in cols[1:0]) at 4 on / 2 off, then a done pulse.
  // A start_round pulse is injected at playback cycle 'poke' (none when negative).
  task automatic expect_play(input logic [7:0] cols, input int n, input int exp_len, input int poke);
    int         cyc;
    logic [1:0] c;
    logic [3:0] exp_led;
    cyc = 0;
    for (int i = 0; i < n; i++) begin
      c       = cols[2*i +: 2];
      exp_led = 4'b0001 << c;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        rnd_in = 8'hFF;
        chk("led_on", 32'(led_onehot), 32'(exp_led));
        chk("seq_len_play", 32'(seq_len), 32'(exp_len));
        chk("busy_play", 32'(busy), 32'd1);
        start_round = (cyc == poke);
        cyc++;
      end
      for (int k = 0; k < 2; k++) begin
        @(negedge clk);
        chk("led_off", 32'(led_onehot), 32'd0);
        chk("done_early", 32'(done), 32'd0);
        start_round = (cyc == poke);
        cyc++;
      end
    end
    @(negedge clk);
    start_round = 1'b0;
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_end", 32'(busy), 32'd0);
    chk("led_end", 32'(led_onehot), 32'd0);
    chk("seq_len_end", 32'(seq_len), 32'(exp_len));
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    rst_n       = 1'b0;
    start_round = 1'b0;
    clear       = 1'b0;
    rnd_in      = 8'h00;
    rd_idx      = 2'd0;
    repeat (3) @(negedge clk);
    chk("rst_seq_len", 32'(seq_len), 32'd0);
    chk("rst_led", 32'(led_onehot), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_seq_len", 32'(seq_len), 32'd0);

    // Rounds 1..4: colours 2, 1, 3, 0
    start_rnd(8'hA6);
    expect_play(8'h02, 1, 1, -1);
    chk("full_after1", 32'(full), 32'd0);
    start_rnd(8'h5D);
    expect_play(8'h06, 2, 2, -1);
    start_rnd(8'hF3);
    expect_play(8'h36, 3, 3, -1);
    start_rnd(8'h3C);
    expect_play(8'h36, 4, 4, -1);
    chk("full_after4", 32'(full), 32'd1);
    rd_idx = 2'd2; #1;
    chk("rd_color_2", 32'(rd_color), 32'd3);
    rd_idx = 2'd0; #1;
    chk("rd_color_0", 32'(rd_color), 32'd2);
    rd_idx = 2'd1; #1;
    chk("rd_color_1", 32'(rd_color), 32'd1);
    rd_idx = 2'd3; #1;
    chk("rd_color_3", 32'(rd_color), 32'd0);

    // Round while full: no append, same playback
    @(negedge clk);
    start_rnd(8'h01);
    expect_play(8'h36, 4, 4, -1);
    chk("full_still", 32'(full), 32'd1);
    rd_idx = 2'd3; #1;
    chk("rd_color_3_kept", 32'(rd_color), 32'd0);

    // clear together with start_round three cycles into a playback
    @(negedge clk);
    start_rnd(8'h02);
    @(negedge clk);
    chk("pre_clear_led_a", 32'(led_onehot), 32'h4);
    @(negedge clk);
    chk("pre_clear_led_b", 32'(led_onehot), 32'h4);
    clear       = 1'b1;
    start_round = 1'b1;
    @(negedge clk);
    clear       = 1'b0;
    start_round = 1'b0;
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_led", 32'(led_onehot), 32'd0);
    chk("clr_seq_len", 32'(seq_len), 32'd0);
    chk("clr_full", 32'(full), 32'd0);
    chk("clr_done", 32'(done), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("clr_quiet_done", 32'(done), 32'd0);
      chk("clr_quiet_busy", 32'(busy), 32'd0);
    end

    // New game; a mid-playback start_round must be ignored
    start_rnd(8'h07);
    expect_play(8'h03, 1, 1, -1);
    rd_idx = 2'd0; #1;
    chk("rd_color_new0", 32'(rd_color), 32'd3);
    @(negedge clk);
    start_rnd(8'h0A);
    expect_play(8'h0B, 2, 2, 5);
    @(negedge clk);
    chk("ignored_busy", 32'(busy), 32'd0);
    chk("ignored_seq_len", 32'(seq_len), 32'd2);

    // Asynchronous reset in the middle of a playback
    start_rnd(8'h01);
    @(negedge clk);
    chk("pre_rst_led", 32'(led_onehot), 32'h8);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_led", 32'(led_onehot), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_seq_len", 32'(seq_len), 32'd0);
    chk("async_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_store.md
Name: seq_store

Overview:
- Downstream consumer of the random-number stage in the Genius game.
- On each new round, appends one colour taken from the random value (low 2 bits) to an on-chip sequence buffer.
- Then plays back the whole sequence to the four colour LEDs with fixed on/off timing.
- Exposes a random-access read port so the player-input checker can compare presses against stored colours.

Parameters:
- DATA_WIDTH, 8, width of rnd_in from the random-number stage; only bits [1:0] are used.
- MAX_LEN, 32, sequence buffer depth (colours); must be at least 2.
- ON_CYCLES, 50000000, clock cycles each colour LED stays lit; must be at least 1.
- OFF_CYCLES, 25000000, dark gap after each colour; must be at least 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- rnd_in  in  DATA_WIDTH  random value from the random-number stage.
- start_round  in  1  pulse: append a colour and play back.
- clear  in  1  pulse: empty the sequence (new game).
- rd_idx  in  $clog2(MAX_LEN)  checker read index.
- rd_color  out  2  colour stored at rd_idx, combinational.
- seq_len  out  $clog2(MAX_LEN+1)  number of stored colours.
- led_onehot  out  4  one-hot LED drive; 0 when dark.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when playback ends.
- full  out  1  seq_len == MAX_LEN.

Behaviour:
- Reset (async, rst_n=0): state IDLE; seq_len=0; led_onehot=0; busy=0; done=0; timers and index=0. Buffer contents are not reset.
- States:
  - IDLE: start_round=1 → APPEND.
  - APPEND (1 cycle):
    - If not full: mem[seq_len] <= rnd_in[1:0]; seq_len++.
    - If full: no write; seq_len unchanged.
    - Next state SHOW_ON, idx=0, timer=0.
  - SHOW_ON: led_onehot = 4'b0001 << mem[idx] for exactly ON_CYCLES cycles → SHOW_OFF, timer=0.
  - SHOW_OFF: led_onehot=0 for exactly OFF_CYCLES cycles.
    - If idx == seq_len-1: → IDLE and pulse done on that IDLE-entry cycle.
    - Else: idx++ → SHOW_ON.
- Latency:
  - start_round sampled at edge t: APPEND during cycle t+1; first LED lit from cycle t+2.
  - Total playback = seq_len*(ON_CYCLES+OFF_CYCLES) cycles.
- rnd_in is sampled only in the APPEND cycle.
- start_round outside IDLE is ignored (not queued).
- clear:
  - Acts in any state: seq_len=0, → IDLE, led_onehot=0, no done pulse.
  - Has priority over a simultaneous start_round.
- Full: rd_color reads mem[rd_idx] for any rd_idx; rd_idx ≥ seq_len returns stale data, and the checker must not use it.
- Reset mid-playback: outputs return to reset values immediately (asynchronous).

Optional Feature:
- Macro SEQ_STORE_REPLAY_EN.
- When defined:
  - Adds input replay (1 bit).
  - replay=1 in IDLE with seq_len>0 → SHOW_ON directly (no APPEND, seq_len unchanged), plays back the sequence, pulses done.
  - replay with seq_len=0 is ignored.
  - start_round has priority over a simultaneous replay.
  - clear has priority over both.
- When undefined: no replay port; behaviour exactly as above.

Test Plan (ON_CYCLES=4, OFF_CYCLES=2, MAX_LEN=4):
- Reset then idle → seq_len=0, led_onehot=0, busy=0, done=0, full=0.
- rnd_in=8'hA6, start_round pulse at edge t:
  - seq_len=1 at t+2; led_onehot=4'b0100 for cycles t+2..t+5; 0 for t+6..t+7.
  - done=1 at t+8; busy low at t+8.
- Three more rounds with rnd_in low bits 1, 3, 0:
  - 4th playback shows 0100, 0010, 1000, 0001, each 4 on / 2 off.
  - Playback lasts 24 cycles; full=1; rd_idx=2 → rd_color=3.
- Fifth start_round while full with rnd_in=8'h01 → seq_len stays 4, mem unchanged, same 4-colour playback, done pulses.
- clear asserted 3 cycles into a playback, same cycle as start_round:
  - Next cycle: IDLE, led_onehot=0, seq_len=0, busy=0, no done pulse.
- start_round asserted mid-playback → ignored: seq_len unchanged; playback timing identical to the undisturbed run.
